uart_rx_os: RTL and testbench

//  Oversampling UART receiver. Decodes the serial line driven by the team's UART transmitter
//  (8N1 or 8E1/8O1, LSB first) into bytes. Presents each byte with per-byte error flags on a

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_os.sv | 153 +++++++++++++++
 tb/tb_uart_rx_os.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, line idle level and the parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic IDLE_BIT = 1'b1;

   function automatic logic uart_parity(input logic [7:0] data, input logic even);
      return even ? ^data : ~^data;
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchroniser (resets to the idle level) plus a tick-qualified falling-edge detect.
module uart_rx_sync
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic clk_en_i,
   input  logic uart_rx_i,
   output logic rx_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // r_prev only follows the line on ticks, so a line held low never produces a second edge.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_sync <= {SYNC_STAGES{IDLE_BIT}};
         r_prev <= IDLE_BIT;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx_i};
         if (clk_en_i) r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign rx_o   = r_sync[SYNC_STAGES-1];
   assign fall_o = clk_en_i & r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-of-3 bit decode, optional parity check, and a
// single-entry valid/ready output register with frame, parity and overrun reporting.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter logic VERIFY_ON   = 1'b0,
   parameter logic VERIFY_EVEN = 1'b0,
   parameter int   OS_RATE     = 16,
   parameter int   SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       clk_en_i,
   input  logic       uart_rx_i,
   output logic [7:0] dataout_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int            CW   = $clog2(OS_RATE);
   localparam logic [CW-1:0] MID  = CW'(OS_RATE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OS_RATE - 1);

   uart_state_e   r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [1:0]    r_samp;
   logic [7:0]    r_shift;
   logic          r_par_err;

   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_frame_err;
   logic          r_parity_err;
   logic          r_overrun;

   logic          w_rx;
   logic          w_fall;
   logic          w_maj;
   logic          w_sample;
   logic          w_mid_p1;
   logic          w_last;
   logic          w_deliver;
   logic          w_free;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i     (clk_i),
      .resetn_i  (resetn_i),
      .clk_en_i  (clk_en_i),
      .uart_rx_i (uart_rx_i),
      .rx_o      (w_rx),
      .fall_o    (w_fall)
   );

   // Third sample is taken live at MID+1, so the decision is made on that tick.
   assign w_sample = (r_cnt == MID - CW'(1)) || (r_cnt == MID);
   assign w_mid_p1 = (r_cnt == MID + CW'(1));
   assign w_last   = (r_cnt == LAST);
   assign w_maj    = majority3(r_samp[1], r_samp[0], w_rx);

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_samp    <= '0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
      end else if (clk_en_i) begin
         if (r_state != IDLE) begin
            if (w_sample) r_samp <= {r_samp[0], w_rx};
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state   <= START;
                  r_cnt     <= '0;
                  r_par_err <= 1'b0;
               end
            end
            START: begin
               if (w_mid_p1 && w_maj) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_last) begin
                  r_state <= DATA;
                  r_idx   <= '0;
               end
            end
            DATA: begin
               if (w_mid_p1) r_shift[r_idx] <= w_maj;
               if (w_last) begin
                  r_idx <= r_idx + 1'b1;
                  if (r_idx == 3'd7) r_state <= VERIFY_ON ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (w_mid_p1) r_par_err <= (w_maj != uart_parity(r_shift, VERIFY_EVEN));
               if (w_last) r_state <= STOP;
            end
            STOP: begin
               if (w_mid_p1) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign w_deliver = clk_en_i && (r_state == STOP) && w_mid_p1;
   assign w_free    = ~r_valid | ready_i;

   // Output register runs every clk_i cycle; an occupied register drops the new byte.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= w_deliver & ~w_free;
         if (w_deliver && w_free) begin
            r_data       <= r_shift;
            r_frame_err  <= ~w_maj;
            r_parity_err <= VERIFY_ON & r_par_err;
            r_valid      <= 1'b1;
         end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign dataout_o    = r_data;
   assign valid_o      = r_valid;
   assign frame_err_o  = r_frame_err;
   assign parity_err_o = r_parity_err;
   assign overrun_o    = r_overrun;
   assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and an 8E1 instance, each with its own expected queue.
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam realtime TICK = 40.0;
   localparam realtime BT   = 640.0;

   logic       clk_i    = 1'b0;
   logic       resetn_i = 1'b0;
   logic       clk_en_i = 1'b0;
   logic       rx_a     = 1'b1;
   logic       rx_p     = 1'b1;
   logic       ready_a  = 1'b1;
   logic       ready_p  = 1'b1;

   logic [7:0] data_a, data_p;
   logic       valid_a, valid_p;
   logic       ferr_a, ferr_p;
   logic       perr_a, perr_p;
   logic       ovr_a, ovr_p;
   logic       busy_a, busy_p;

   logic [9:0] exp_a[$];
   logic [9:0] exp_p[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc_a = 0;
   int n_vcyc_a = 0;
   int n_ovr_a = 0;
   int n_acc_p = 0;
   bit fast_en = 1'b0;
   int en_cnt  = 0;

   uart_rx_os #(
      .VERIFY_ON(1'b0), .VERIFY_EVEN(1'b0), .OS_RATE(16), .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk_i), .resetn_i(resetn_i), .clk_en_i(clk_en_i), .uart_rx_i(rx_a),
      .dataout_o(data_a), .valid_o(valid_a), .ready_i(ready_a), .frame_err_o(ferr_a),
      .parity_err_o(perr_a), .overrun_o(ovr_a), .busy_o(busy_a)
   );

   uart_rx_os #(
      .VERIFY_ON(1'b1), .VERIFY_EVEN(1'b1), .OS_RATE(16), .SYNC_STAGES(2)
   ) dut_p (
      .clk_i(clk_i), .resetn_i(resetn_i), .clk_en_i(clk_en_i), .uart_rx_i(rx_p),
      .dataout_o(data_p), .valid_o(valid_p), .ready_i(ready_p), .frame_err_o(ferr_p),
      .parity_err_o(perr_p), .overrun_o(ovr_p), .busy_o(busy_p)
   );

   // Clock and oversampling enable
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      #1;
      en_cnt++;
      clk_en_i = fast_en || (en_cnt % 4 == 0);
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitors: compare {parity_err, frame_err, data} on each accepted byte
   always @(negedge clk_i) begin
      if (valid_a) n_vcyc_a++;
      if (ovr_a) n_ovr_a++;
      if (valid_a && ready_a) begin
         n_acc_a++;
         if (exp_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_unexpected: got 0x%0h, expected no byte", {perr_a, ferr_a, data_a});
         end else begin
            check("a_byte", {22'd0, perr_a, ferr_a, data_a}, {22'd0, exp_a.pop_front()});
         end
      end
      if (valid_p && ready_p) begin
         n_acc_p++;
         if (exp_p.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL p_unexpected: got 0x%0h, expected no byte", {perr_p, ferr_p, data_p});
         end else begin
            check("p_byte", {22'd0, perr_p, ferr_p, data_p}, {22'd0, exp_p.pop_front()});
         end
      end
   end

   // Driver tasks
   task automatic drive(input bit sel_p, input logic v);
      if (sel_p) rx_p = v;
      else rx_a = v;
   endtask

   // Leaves the line at the stop-bit level; callers return it to idle.
   task automatic send_frame(input bit sel_p, input logic [7:0] d, input bit has_par,
                             input logic par, input logic stop, input realtime bt);
      @(posedge clk_i);
      #3;
      drive(sel_p, 1'b0);
      #(bt);
      for (int i = 0; i < 8; i++) begin
         drive(sel_p, d[i]);
         #(bt);
      end
      if (has_par) begin
         drive(sel_p, par);
         #(bt);
      end
      drive(sel_p, stop);
      #(bt);
   endtask

   task automatic send_a(input logic [7:0] d, input realtime bt);
      send_frame(1'b0, d, 1'b0, 1'b0, 1'b1, bt);
      drive(1'b0, 1'b1);
      #(2 * bt);
   endtask

   task automatic set_ready_a(input logic v);
      @(posedge clk_i);
      #2;
      ready_a = v;
   endtask

   task automatic wait_drain(input string nm);
      for (int k = 0; k < 4000 && (exp_a.size() != 0 || exp_p.size() != 0); k++) @(posedge clk_i);
      @(negedge clk_i);
      check({nm, "_drain"}, exp_a.size() + exp_p.size(), 0);
   endtask

   initial begin
      int a0, v0, o0;
      logic [7:0] mm_bytes [4];
      realtime    mm_bt [2];
      mm_bytes = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
      mm_bt    = '{160.0 * 1.03, 160.0 * 0.97};

      // Reset state
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_valid", valid_a, 0);
      check("rst_data", data_a, 0);
      check("rst_flags", {ferr_a, perr_a, ovr_a}, 0);
      check("rst_busy", busy_a, 0);
      @(posedge clk_i);
      #2;
      resetn_i = 1'b1;
      repeat (20) @(posedge clk_i);

      // 1: 8N1 0xA5, ready held high -> one-cycle valid
      v0 = n_vcyc_a;
      exp_a.push_back(10'h0A5);
      send_a(8'hA5, BT);
      wait_drain("t1");
      check("t1_valid_cycles", n_vcyc_a - v0, 1);

      // 2: even parity, 0x3C (four ones) -> parity 0 good, parity 1 bad
      exp_p.push_back(10'h03C);
      send_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, BT);
      drive(1'b1, 1'b1);
      #(2 * BT);
      exp_p.push_back(10'h23C);
      send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, BT);
      drive(1'b1, 1'b1);
      #(2 * BT);
      wait_drain("t2");
      check("t2_count", n_acc_p, 2);

      // 3: 5-tick glitch is rejected
      a0 = n_acc_a;
      v0 = n_vcyc_a;
      @(posedge clk_i);
      #3;
      drive(1'b0, 1'b0);
      #(3 * TICK);
      check("t3_busy_rise", busy_a, 1);
      #(2 * TICK);
      drive(1'b0, 1'b1);
      #(10 * TICK);
      check("t3_busy_fall", busy_a, 0);
      #(2 * BT);
      check("t3_no_valid", n_vcyc_a - v0, 0);

      // 4: stop bit 0 then a held break -> exactly one errored byte
      a0 = n_acc_a;
      exp_a.push_back(10'h155);
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, BT);
      #(30 * BT);
      @(negedge clk_i);
      check("t4_one_byte", n_acc_a - a0, 1);
      check("t4_idle_in_break", busy_a, 0);
      drive(1'b0, 1'b1);
      #(3 * BT);
      check("t4_no_more", n_acc_a - a0, 1);
      exp_a.push_back(10'h0C3);
      send_a(8'hC3, BT);
      wait_drain("t4");

      // 5: consumer stalled -> second byte dropped with one overrun pulse
      set_ready_a(1'b0);
      o0 = n_ovr_a;
      exp_a.push_back(10'h011);
      send_a(8'h11, BT);
      send_a(8'h22, BT);
      @(negedge clk_i);
      check("t5_valid_held", valid_a, 1);
      check("t5_data_held", data_a, 8'h11);
      check("t5_overrun_once", n_ovr_a - o0, 1);
      set_ready_a(1'b1);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("t5_valid_fall", valid_a, 0);
      wait_drain("t5");

      // 6: reset during data bit 4 of 0x5A aborts it; 0x81 follows
      fork
         begin
            send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, BT);
            drive(1'b0, 1'b1);
         end
         begin
            #(5 * BT + BT / 2);
            check("t6_busy_pre", busy_a, 1);
            resetn_i = 1'b0;
            #(3 * TICK);
            @(negedge clk_i);
            check("t6_rst_data", data_a, 0);
            check("t6_rst_busy", busy_a, 0);
            check("t6_rst_valid", {valid_a, ferr_a, perr_a, ovr_a}, 0);
         end
      join
      #(BT);
      @(posedge clk_i);
      #2;
      resetn_i = 1'b1;
      repeat (10) @(posedge clk_i);
      a0 = n_acc_a;
      exp_a.push_back(10'h081);
      send_a(8'h81, BT);
      wait_drain("t6");
      check("t6_count", n_acc_a - a0, 1);

      // 7: clk_en_i stuck high with +/-3% baud error
      fast_en = 1'b1;
      repeat (10) @(posedge clk_i);
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 4; i++) begin
            exp_a.push_back({2'b00, mm_bytes[i]});
            send_a(mm_bytes[i], mm_bt[b]);
         end
      end
      wait_drain("t7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
